// File: rtl/rdma_axis_pkg.sv
// Shared definitions for the RDMA TX AXI-Stream blocks.
// Contents:
//   ARB_FIXED / ARB_RR      arbitration mode selectors
//   TX_*_WIDTH              default TX AXIS field widths
//   arb_state_e             packet-lock state of the TX arbiter
//   clog2_min1()            select-index width helper (never below 1)
package rdma_axis_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  localparam int unsigned TX_DATA_WIDTH = 512;
  localparam int unsigned TX_ID_WIDTH   = 10;
  localparam int unsigned TX_DEST_WIDTH = 5;
  localparam int unsigned TX_USER_WIDTH = 232;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCK
  } arb_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Generic 2-entry AXI-Stream register slice (output register + skid register).
// The whole beat (data and sideband) travels as one opaque payload vector.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_data/s_valid    upstream beat
//   s_ready           registered ready (low while the skid entry is occupied)
//   m_data/m_valid    registered downstream beat
//   m_ready           downstream ready
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q, ready_d;
  logic             accept;

  assign accept  = s_valid & ready_q;
  assign s_ready = ready_q;
  assign m_data  = out_data_q;
  assign m_valid = out_valid_q;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_ready) begin
      // Output register frees up: the older skid beat goes first. Ready was
      // low while the skid entry was full, so no new beat competes with it.
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = s_data;
        end
      end
    end else if (accept) begin
      skid_data_d  = s_data;
      skid_valid_d = 1'b1;
    end
    // Ready is registered from the next skid occupancy; it stays low for the
    // first cycle after reset.
    ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: rtl/tx_axis_pkt_arb_mux.sv
// RDMA TX packet arbiter/mux: merges S_COUNT AXI-Stream sources onto one
// registered output stream. Grants change only on packet boundaries.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_axis_*           packed per-source inputs (slice i = source i)
//   s_axis_tready      per-source ready (only the granted source)
//   m_axis_*           merged, registered output stream
//   sel_index          last granted source
//   sel_busy           high while a multi-beat packet holds the lock
module tx_axis_pkt_arb_mux
  import rdma_axis_pkg::*;
#(
  parameter int unsigned S_COUNT    = 2,
  parameter int unsigned DATA_WIDTH = TX_DATA_WIDTH,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = TX_ID_WIDTH,
  parameter int unsigned DEST_WIDTH = TX_DEST_WIDTH,
  parameter int unsigned USER_WIDTH = TX_USER_WIDTH,
  parameter int unsigned ARB_MODE   = ARB_FIXED,
  parameter int unsigned CL_S_COUNT = clog2_min1(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]   s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [CL_S_COUNT-1:0]         sel_index,
  output logic                          sel_busy
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  arb_state_e              state_q, state_d;
  logic [CL_S_COUNT-1:0]   lock_idx_q, lock_idx_d;
  logic [CL_S_COUNT-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CL_S_COUNT-1:0]   sel_idx_q, sel_idx_d;
  logic [CL_S_COUNT-1:0]   arb_idx, grant_idx;
  logic                    arb_any, grant_en, accept, int_ready;
  logic [PW-1:0]           in_payload, out_payload;
  int unsigned             cand;

  // Combinational arbitration so the first beat is accepted in the grant
  // cycle. Candidates are visited lowest-priority first; the last hit wins.
  always_comb begin
    arb_any = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < S_COUNT; k++) begin
      if (ARB_MODE == ARB_RR) begin
        cand = (32'(rr_ptr_q) + S_COUNT - 1 - k) % S_COUNT;
      end else begin
        cand = k;
      end
      if (s_axis_tvalid[cand]) begin
        arb_any = 1'b1;
        arb_idx = CL_S_COUNT'(cand);
      end
    end
  end

  always_comb begin
    grant_en  = (state_q == ARB_LOCK) || arb_any;
    grant_idx = (state_q == ARB_LOCK) ? lock_idx_q : arb_idx;
    s_axis_tready = '0;
    if (grant_en) begin
      s_axis_tready[grant_idx] = int_ready;
    end
    accept     = grant_en & int_ready & s_axis_tvalid[grant_idx];
    in_payload = {s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH],
                  s_axis_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH],
                  s_axis_tlast[grant_idx],
                  s_axis_tid[grant_idx*ID_WIDTH +: ID_WIDTH],
                  s_axis_tdest[grant_idx*DEST_WIDTH +: DEST_WIDTH],
                  s_axis_tuser[grant_idx*USER_WIDTH +: USER_WIDTH]};
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    sel_idx_d  = sel_idx_q;
    if (accept) begin
      sel_idx_d = grant_idx;
      if (s_axis_tlast[grant_idx]) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (32'(grant_idx) == S_COUNT - 1) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d    = ARB_LOCK;
        lock_idx_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      sel_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      sel_idx_q  <= sel_idx_d;
    end
  end

  axis_skid_reg #(
    .WIDTH(PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (in_payload),
    .s_valid (accept),
    .s_ready (int_ready),
    .m_data  (out_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser} = out_payload;
  assign sel_index = sel_idx_q;
  assign sel_busy  = (state_q == ARB_LOCK);

endmodule

// File: doc/tx_axis_pkt_arb_mux.md
Name: tx_axis_pkt_arb_mux

Overview:
- Parametrised N-input AXI-Stream arbiter/mux for the RDMA TX path. It merges S_COUNT packet sources (e.g. control-unit, retransmit engine, future QP engines) onto one TX stream towards the NIC interface.
- Arbitration happens on packet boundaries only: a granted source keeps the output until its tlast beat transfers.
- Selectable fixed-priority or round-robin mode.
- Registered output with a skid buffer, giving full throughput with no combinational tready path from m_axis to s_axis.

Parameters:
- S_COUNT, 2, number of input streams (1..16).
- DATA_WIDTH, 512, tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ID_WIDTH, 10, tid width.
- DEST_WIDTH, 5, tdest width.
- USER_WIDTH, 232, tuser width.
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin.
- CL_S_COUNT, $clog2(S_COUNT) (min 1), width of the select index.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed input data; slice i belongs to source i.
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed input keep.
- s_axis_tvalid  in  S_COUNT  per-source valid.
- s_axis_tready  out  S_COUNT  per-source ready.
- s_axis_tlast  in  S_COUNT  per-source last.
- s_axis_tid  in  S_COUNT*ID_WIDTH  packed input id.
- s_axis_tdest  in  S_COUNT*DEST_WIDTH  packed input dest.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed input user.
- m_axis_tdata/tkeep/tvalid/tlast/tid/tdest/tuser  out  widths as parameters  merged output.
- m_axis_tready  in  1  output ready.
- sel_index  out  CL_S_COUNT  currently granted source.
- sel_busy  out  1  high while a packet is locked.

Behaviour:
- Reset (rst_n low, asynchronous): lock cleared, round-robin pointer = 0, skid buffer empty.
  - m_axis_tvalid = 0, s_axis_tready = 0, sel_busy = 0, sel_index = 0.
  - All data outputs = 0.
- Clock and reset are fixed as above: one clock, asynchronous active-low reset.
- Internal ready: int_ready = ~skid_valid (registered).
- States:
  - IDLE (no lock):
    - Combinational arbitration over s_axis_tvalid, so the first beat can be accepted in the same cycle.
    - Fixed mode: highest-index requester wins, matching the "retransmit preempts" priority.
    - RR mode: first requester at or above rr_ptr, wrapping modulo S_COUNT.
    - s_axis_tready[g] = int_ready for the winner g; 0 for all others.
    - If the winner's beat transfers with tlast = 0: go to LOCK(g), sel_busy = 1, sel_index = g.
    - If it transfers with tlast = 1 (single-beat packet): stay IDLE and re-arbitrate next cycle.
  - LOCK(g):
    - Only source g is ready (s_axis_tready[g] = int_ready).
    - A tvalid gap from g holds the lock and produces an output bubble; other sources are never granted mid-packet.
    - When g's tlast beat transfers: go to IDLE next cycle.
- Round-robin pointer: on every accepted tlast from g, rr_ptr = g+1 (wraps to 0 at S_COUNT). Fixed mode ignores rr_ptr.
- Output stage (two-register skid buffer):
  - Accepted beat goes to the output register when it is empty or m_axis_tready = 1; otherwise it goes to the skid register.
  - Latency from input accept to m_axis_tvalid is 1 cycle. Sustained throughput is 1 beat/cycle.
  - At most 2 beats in flight. Beat order and all sideband fields are preserved bit-exact.
- m_axis_tvalid stays high until m_axis_tready; data is held stable while stalled.
- Simultaneous events:
  - Output drain and new accept in the same cycle are both allowed.
  - tlast accept and a new request in the same cycle: the new grant takes effect the next cycle (one idle arbitration cycle only when the source is not the same winner).
- S_COUNT = 1: arbiter degenerates to a pass-through with the register stage; sel_index = 0.
- Reset mid-packet: the partial packet is dropped and no lock is retained. The upstream source must restart its packet.

Decomposition:
- Shared package rdma_axis_pkg: ARB_FIXED/ARB_RR constants and the default TX AXIS widths (512/10/5/232).
- One natural sub-module: axis_skid_reg, the generic 2-entry register slice with tdata/tkeep/tlast/tid/tdest/tuser packed into one payload vector. It is reused by other TX blocks.
- Arbiter and lock logic stay in the top module.

Test Plan:
- S_COUNT=2, fixed mode; src0 sends a 4-beat packet, src1 raises tvalid at beat 2 → src1 is not ready until src0's tlast transfers; output shows 4 src0 beats then src1 beats, with no interleave.
- Both sources valid together at idle, fixed mode → src1 granted first; sel_index = 1; first output beat appears 1 cycle after accept.
- S_COUNT=4, RR mode; all sources continuously send 1-beat packets → output tid order is 0,1,2,3,0,…; no source starves over 64 packets.
- m_axis_tready toggled randomly (50%) during a 16-beat packet → all 16 beats out in order, data bit-exact, no drops or duplicates; with ready held at 1, m_axis_tvalid stays high for 16 consecutive cycles.
- Granted source drops tvalid for 3 cycles mid-packet while another source requests → lock held, sel_busy = 1, output bubble of 3 cycles, no grant change.
- rst_n pulsed low mid-packet → m_axis_tvalid = 0 and s_axis_tready = 0 immediately (asynchronously); after release, rr_ptr = 0 and sel_busy = 0.
